// File: rtl/writeback_regfile_pkg.sv
// Shared CPU constants for the writeback stage, ALU and forwarding unit.
package writeback_regfile_pkg;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int REG_COUNT   = 2 ** ADDR_W;
  localparam int UPPER_SHIFT = 16;
  localparam int RD_PORTS    = 2;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              upper;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
  } wb_req_t;
endpackage

// File: rtl/writeback_regfile_if.sv
// W-stage write bundle, D-stage read ports and debug counter between pipeline and regfile.
interface writeback_regfile_if;
  import writeback_regfile_pkg::*;

  logic              reg_write_w;
  logic              mem_to_reg_w;
  logic [DATA_W-1:0] alu_result_w;
  logic [DATA_W-1:0] read_data_w;
  logic [ADDR_W-1:0] write_reg_w;
  logic              upper_w;
  logic [ADDR_W-1:0] read_reg1_d;
  logic [ADDR_W-1:0] read_reg2_d;
  logic [DATA_W-1:0] read_data1_d;
  logic [DATA_W-1:0] read_data2_d;
  logic [DATA_W-1:0] result_w;
  logic [31:0]       retire_count;

  modport master (
    output reg_write_w, mem_to_reg_w, alu_result_w, read_data_w, write_reg_w, upper_w,
           read_reg1_d, read_reg2_d,
    input  read_data1_d, read_data2_d, result_w, retire_count
  );

  modport slave (
    input  reg_write_w, mem_to_reg_w, alu_result_w, read_data_w, write_reg_w, upper_w,
           read_reg1_d, read_reg2_d,
    output read_data1_d, read_data2_d, result_w, retire_count
  );
endinterface

// File: rtl/writeback_regfile_wb_result_mux.sv
// Writeback result select; load-upper beats the mem/alu choice.
module wb_result_mux
  import writeback_regfile_pkg::*;
(
  input  logic              upper_i,
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] read_data_i,
  output logic [DATA_W-1:0] result_o
);
  always_comb begin
    if (upper_i)
      result_o = alu_result_i << UPPER_SHIFT;
    else if (mem_to_reg_i)
      result_o = read_data_i;
    else
      result_o = alu_result_i;
  end
endmodule

// File: rtl/writeback_regfile.sv
// 32-entry architectural regfile with W-stage commit, write-through read bypass and retire counter.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  writeback_regfile_if.slave   wb
);
  wb_req_t                            req;
  logic [DATA_W-1:0]                  result;
  logic                               commit;
  logic [REG_COUNT-1:0][DATA_W-1:0]   regs_q;
  logic [31:0]                        retire_q, retire_d;
  logic [RD_PORTS-1:0][ADDR_W-1:0]    rd_idx;
  logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data;

  assign req = '{reg_write:  wb.reg_write_w,
                 mem_to_reg: wb.mem_to_reg_w,
                 upper:      wb.upper_w,
                 write_reg:  wb.write_reg_w,
                 alu_result: wb.alu_result_w,
                 read_data:  wb.read_data_w};

  wb_result_mux u_mux (
    .upper_i      (req.upper),
    .mem_to_reg_i (req.mem_to_reg),
    .alu_result_i (req.alu_result),
    .read_data_i  (req.read_data),
    .result_o     (result)
  );

  assign commit   = req.reg_write && (req.write_reg != REG_ZERO) && !reset;
  assign retire_d = retire_q + 32'd1;

  // Entry 0 is only ever cleared, never written, so it stays at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q   <= '0;
      retire_q <= '0;
    end else if (commit) begin
      regs_q[req.write_reg] <= result;
      retire_q              <= retire_d;
    end
  end

  assign rd_idx[0] = wb.read_reg1_d;
  assign rd_idx[1] = wb.read_reg2_d;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    always_comb begin
      rd_data[p] = regs_q[rd_idx[p]];
      if (reset || rd_idx[p] == REG_ZERO)
        rd_data[p] = '0;
      else if (commit && req.write_reg == rd_idx[p])
        rd_data[p] = result;
    end
  end

  assign wb.read_data1_d = rd_data[0];
  assign wb.read_data2_d = rd_data[1];
  assign wb.result_w     = result;
  assign wb.retire_count = retire_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed checks of writeback_regfile: mux paths, bypass, $0, reset.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  writeback_regfile_if wb ();

  writeback_regfile dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                    input logic m2r, input logic up);
    wb.reg_write_w  = 1'b1;
    wb.write_reg_w  = rd;
    wb.alu_result_w = alu;
    wb.read_data_w  = ld;
    wb.mem_to_reg_w = m2r;
    wb.upper_w      = up;
  endtask

  task automatic idle();
    wb.reg_write_w  = 1'b0;
    wb.mem_to_reg_w = 1'b0;
    wb.upper_w      = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    wb.read_reg1_d = a;
    wb.read_reg2_d = b;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wb.write_reg_w = '0; wb.alu_result_w = '0; wb.read_data_w = '0;
    rd(5'd0, 5'd0);
    tick(); tick();
    rd(5'd4, 5'd6);
    #1;
    chk("rst_rd1", wb.read_data1_d, 32'h0);
    chk("rst_rd2", wb.read_data2_d, 32'h0);
    chk("rst_cnt", wb.retire_count, 32'h0);
    reset = 1'b0;

    // ALU path
    wr(5'd5, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    #1 chk("alu_res", wb.result_w, 32'h1234_5678);
    tick(); idle(); rd(5'd5, 5'd5);
    #1;
    chk("alu_r5", wb.read_data1_d, 32'h1234_5678);
    chk("alu_cnt", wb.retire_count, 32'd1);

    // Load path
    wr(5'd9, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick(); idle(); rd(5'd5, 5'd9);
    #1;
    chk("ld_r9", wb.read_data2_d, 32'hDEAD_BEEF);
    chk("ld_r5", wb.read_data1_d, 32'h1234_5678);
    chk("ld_cnt", wb.retire_count, 32'd2);

    // Load-upper overrides mem_to_reg
    wr(5'd3, 32'hAAAA_00FF, 32'h1111_2222, 1'b1, 1'b1);
    #1 chk("up_res", wb.result_w, 32'h00FF_0000);
    tick(); idle(); rd(5'd3, 5'd0);
    #1;
    chk("up_r3", wb.read_data1_d, 32'h00FF_0000);
    chk("up_cnt", wb.retire_count, 32'd3);

    // Seed r7, then bypass
    wr(5'd7, 32'h0000_0011, 32'h0, 1'b0, 1'b0);
    tick();
    wr(5'd7, 32'hCAFE_0001, 32'h0, 1'b0, 1'b0);
    wb.reg_write_w = 1'b0;
    rd(5'd7, 5'd7);
    #1;
    chk("nobyp_rd1", wb.read_data1_d, 32'h0000_0011);
    chk("nobyp_rd2", wb.read_data2_d, 32'h0000_0011);
    wb.reg_write_w = 1'b1;
    #1;
    chk("byp_rd1", wb.read_data1_d, 32'hCAFE_0001);
    chk("byp_rd2", wb.read_data2_d, 32'hCAFE_0001);
    tick(); idle();
    #1;
    chk("byp_r7", wb.read_data1_d, 32'hCAFE_0001);
    chk("byp_cnt", wb.retire_count, 32'd5);

    // $0 write is ignored
    wr(5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    rd(5'd0, 5'd0);
    #1;
    chk("z_res", wb.result_w, 32'hFFFF_FFFF);
    chk("z_rd1_same", wb.read_data1_d, 32'h0);
    tick(); idle();
    #1;
    chk("z_rd1_after", wb.read_data1_d, 32'h0);
    chk("z_cnt", wb.retire_count, 32'd5);

    // Mid-stream reset with a colliding write
    wr(5'd1, 32'd1, 32'h0, 1'b0, 1'b0);
    tick();
    wr(5'd31, 32'd31, 32'h0, 1'b0, 1'b0);
    tick();
    idle(); rd(5'd1, 5'd31);
    #1;
    chk("pre_r1", wb.read_data1_d, 32'd1);
    chk("pre_r31", wb.read_data2_d, 32'd31);
    chk("pre_cnt", wb.retire_count, 32'd7);
    reset = 1'b1;
    wr(5'd2, 32'h55, 32'h0, 1'b0, 1'b0);
    rd(5'd1, 5'd2);
    #1;
    chk("rsthi_rd1", wb.read_data1_d, 32'h0);
    chk("rsthi_rd2", wb.read_data2_d, 32'h0);
    tick();
    chk("rsthi_cnt", wb.retire_count, 32'h0);
    reset = 1'b0;
    idle(); rd(5'd1, 5'd2);
    #1;
    chk("post_r1", wb.read_data1_d, 32'h0);
    chk("post_r2", wb.read_data2_d, 32'h0);
    rd(5'd31, 5'd5);
    #1;
    chk("post_r31", wb.read_data1_d, 32'h0);
    chk("post_r5", wb.read_data2_d, 32'h0);

    // First write after reset commits normally
    wr(5'd2, 32'h77, 32'h0, 1'b0, 1'b0);
    tick(); idle(); rd(5'd2, 5'd0);
    #1;
    chk("after_r2", wb.read_data1_d, 32'h77);
    chk("after_cnt", wb.retire_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Consumer end of the MEM/WB pipeline register: takes the W-stage control and data fields, forms the writeback result, and commits it into the 32-entry architectural register file. It also provides the two decode-stage read ports, with write-through bypass so a D-stage read sees a same-cycle W-stage write. It exports the W result for the forwarding unit and a committed-write counter for debug.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register index width
REG_COUNT, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
reg_write_w  input  1  W-stage register write enable
mem_to_reg_w  input  1  1 selects read_data_w, 0 selects alu_result_w
alu_result_w  input  DATA_W  ALU result from MEM/WB
read_data_w  input  DATA_W  load data from MEM/WB
write_reg_w  input  ADDR_W  destination register index
upper_w  input  1  load-upper: result is low half shifted to the top
read_reg1_d  input  ADDR_W  D-stage source register 1 index
read_reg2_d  input  ADDR_W  D-stage source register 2 index
read_data1_d  output  DATA_W  source 1 value, combinational
read_data2_d  output  DATA_W  source 2 value, combinational
result_w  output  DATA_W  W-stage result, combinational, for forwarding
retire_count  output  32  registered count of committed register writes

Behaviour:
- Result mux (combinational). upper_w=1 -> result_w = {alu_result_w[15:0], 16'h0000}, and upper_w takes priority over mem_to_reg_w. Otherwise mem_to_reg_w=1 -> read_data_w; else alu_result_w.
- Commit condition: commit = reg_write_w && (write_reg_w != 0) && !reset.
- On posedge clk with commit, regs[write_reg_w] <= result_w. Latency is 1 edge.
- Register 0 is hardwired to zero. It is never stored and always reads as 0, including on the bypass path.
- Read port n (combinational), in priority order:
  - reset=1 -> 0.
  - read_reg_n == 0 -> 0.
  - commit && write_reg_w == read_reg_n -> result_w (write-through bypass).
  - Otherwise regs[read_reg_n].
- Both read ports may address the same register, or the write target, in the same cycle. Each resolves independently by the rules above.
- retire_count:
  - Increments by 1 on each posedge where commit=1.
  - Wraps from 32'hFFFFFFFF to 0.
  - Writes to $0 and writes with reg_write_w=0 are not counted.
- Reset (synchronous): on a posedge with reset=1, all registers 1..31 go to 0 and retire_count goes to 0.
  - A write presented in the same cycle as reset is dropped.
  - Reset asserted mid-stream discards no already-committed state except by clearing it. The first write after reset deasserts commits normally on the next edge.
- The initial state after power-up is undefined until the first reset edge. Benches must reset first.
- result_w is driven regardless of reg_write_w. Consumers qualify it with reg_write_w themselves.

Decomposition:
- Shared cpu package: DATA_W and ADDR_W constants, the REG_ZERO index constant, and the UPPER_SHIFT (16) constant, shared with the ALU and forwarding unit.
- One natural sub-module, wb_result_mux: the combinational upper/mem/alu select producing result_w. The top instantiates it alongside the register array, the bypass logic and the counter.

Test Plan:
- Reset, then write ALU path (reg_write_w=1, mem_to_reg_w=0, alu_result_w=32'h1234_5678, write_reg_w=5). After the edge, read_reg1_d=5 gives 32'h1234_5678 and retire_count=1.
- Load path (mem_to_reg_w=1, read_data_w=32'hDEAD_BEEF, alu_result_w=32'h0000_0040, write_reg_w=9). r9 reads 32'hDEAD_BEEF.
- Upper path with upper_w=1 and mem_to_reg_w=1 (alu_result_w=32'hAAAA_00FF, write_reg_w=3). result_w is 32'h00FF_0000 in the same cycle, r3 is 32'h00FF_0000 after the edge, and read_data_w is ignored.
- Same-cycle bypass: write 32'hCAFE_0001 to r7 while read_reg1_d=7 and read_reg2_d=7. Both outputs show 32'hCAFE_0001 before the edge. With reg_write_w=0 and the same inputs, both show the old r7.
- $0 protection: write 32'hFFFF_FFFF to r0. read_data1_d at index 0 stays 0 in that cycle and afterwards, and retire_count is unchanged.
- Reset mid-operation: populate r1=1 and r31=31, then assert reset together with a write to r2=32'h55. After the edge, r1, r2 and r31 read 0, retire_count=0, and both read outputs are 0 while reset is high.
